// File: rtl/control_stall_unit_pkg.sv
// control_stall_unit_pkg
//   Shared constants for the stall/flush controller:
//   - miss-handling FSM state encodings (ST_RUN / ST_DMISS / ST_IMISS)
//   - symbolic values for the branch-resolve stage parameter (BR_EX / BR_MEM)
//   - width of the FSM state vector
package control_stall_unit_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_RUN   = 2'd0;
    localparam logic [STATE_W-1:0] ST_DMISS = 2'd1;
    localparam logic [STATE_W-1:0] ST_IMISS = 2'd2;

    // Stage in which a taken branch is known
    localparam int BR_EX  = 2;
    localparam int BR_MEM = 3;

endpackage

// File: rtl/control_stall_unit_sat_counter.sv
// control_stall_unit_sat_counter
//   Saturating up-counter with synchronous clear, used for the
//   stall / flush / miss performance events.
//   Ports:
//     clock  in        core clock
//     clr    in        synchronous clear (dominates inc)
//     inc    in        count one event this cycle
//     count  out CNT_W current value, sticks at all-ones
module control_stall_unit_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/control_stall_unit.sv
// control_stall_unit
//   ID-stage stall/flush controller for the 5-stage core with L1 caches.
//   Merges D-cache miss stalls, taken-branch flushes, I-cache miss stalls,
//   load-use stalls and jump flushes (in that priority) into per-stage
//   bubble / write enables and the PC write enable.
//   Ports:
//     clock, reset                       clock, synchronous active-high reset
//     ifid_rs, ifid_rt                   sources of the instruction in ID
//     idex_rd, idex_memread              destination / load flag in EX
//     exmem_rd, exmem_memread            destination / load flag in MEM
//     exmem_memaccess                    MEM instruction uses the D-cache
//     Jump, PCSrc                        jump in ID, taken branch at BR_STAGE
//     icache_ready, dcache_ready         cache completion handshakes
//     bubble_*                           insert NOP into that pipeline register
//     write_*                            pipeline register / PC enables
//     stall_cnt, flush_cnt, miss_cnt     saturating event counters
//     dbg_state, dbg_drop_fetch          FSM state and pending-discard flag
//
//   Cache handshake: the controller never requests; a cache access that is
//   in flight completes in the cycle its ready is 1, and every cycle its
//   ready is 0 the affected stages hold. Ready is sampled every cycle and
//   needs no acknowledge.
module control_stall_unit
    import control_stall_unit_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int BR_STAGE = 3,
    parameter int CNT_W    = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [REG_W-1:0]   ifid_rs,
    input  logic [REG_W-1:0]   ifid_rt,
    input  logic [REG_W-1:0]   idex_rd,
    input  logic               idex_memread,
    input  logic [REG_W-1:0]   exmem_rd,
    input  logic               exmem_memread,
    input  logic               exmem_memaccess,
    input  logic               Jump,
    input  logic               PCSrc,
    input  logic               icache_ready,
    input  logic               dcache_ready,
    output logic               bubble_ifid,
    output logic               bubble_idex,
    output logic               bubble_exmem,
    output logic               bubble_memwb,
    output logic               write_ifid,
    output logic               write_idex,
    output logic               write_exmem,
    output logic               write_memwb,
    output logic               write_pc,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic [CNT_W-1:0]   miss_cnt,
    output logic [STATE_W-1:0] dbg_state,
    output logic               dbg_drop_fetch
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               drop_fetch_q, drop_fetch_d;
    logic               d_stall;
    logic               load_use;
    logic               branch_act;
    logic               jump_act;

    always_comb begin
        state_d      = state_q;
        drop_fetch_d = drop_fetch_q;
        bubble_ifid  = 1'b0;
        bubble_idex  = 1'b0;
        bubble_exmem = 1'b0;
        bubble_memwb = 1'b0;
        write_ifid   = 1'b1;
        write_idex   = 1'b1;
        write_exmem  = 1'b1;
        write_memwb  = 1'b1;
        write_pc     = 1'b1;
        branch_act   = 1'b0;
        jump_act     = 1'b0;

        // Once in DMISS the frozen MEM instruction keeps the access alive,
        // so only dcache_ready decides whether the stall continues.
        if (state_q == ST_DMISS) begin
            d_stall = !dcache_ready;
        end else begin
            d_stall = exmem_memaccess && !dcache_ready;
        end

        // Register 0 is hard-wired, so a load into it never creates a hazard.
        load_use = idex_memread && (idex_rd != '0) &&
                   ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));
        if (LOAD_LAT == 2) begin
            load_use = load_use ||
                       (exmem_memread && (exmem_rd != '0) &&
                        ((exmem_rd == ifid_rs) || (exmem_rd == ifid_rt)));
        end

        if (d_stall) begin
            // Freeze everything up to MEM; MEM/WB drains a bubble.
            write_pc     = 1'b0;
            write_ifid   = 1'b0;
            write_idex   = 1'b0;
            write_exmem  = 1'b0;
            bubble_memwb = 1'b1;
            state_d      = ST_DMISS;
        end else if (PCSrc) begin
            branch_act  = 1'b1;
            bubble_ifid = 1'b1;
            bubble_idex = 1'b1;
            write_pc    = 1'b1;
            if (BR_STAGE == BR_MEM) begin
                bubble_exmem = 1'b1;
            end
            // The outstanding fetch belongs to the wrong path: remember to
            // throw it away when it finally arrives.
            if ((state_q == ST_IMISS) && !icache_ready) begin
                drop_fetch_d = 1'b1;
                state_d      = ST_IMISS;
            end else begin
                state_d = ST_RUN;
                if (icache_ready) begin
                    drop_fetch_d = 1'b0;
                end
            end
        end else if (!icache_ready) begin
            // Covers entering IMISS from RUN, staying in IMISS, and an
            // I-miss seen on the DMISS release cycle.
            write_pc    = 1'b0;
            bubble_ifid = 1'b1;
            state_d     = ST_IMISS;
        end else begin
            state_d = ST_RUN;
            if (drop_fetch_q) begin
                bubble_ifid  = 1'b1;
                drop_fetch_d = 1'b0;
            end
            if (load_use) begin
                write_pc    = 1'b0;
                write_ifid  = 1'b0;
                bubble_idex = 1'b1;
            end else if (Jump) begin
                jump_act    = 1'b1;
                bubble_ifid = 1'b1;
            end
        end

        if (reset) begin
            bubble_ifid  = 1'b1;
            bubble_idex  = 1'b1;
            bubble_exmem = 1'b1;
            bubble_memwb = 1'b1;
            write_ifid   = 1'b1;
            write_idex   = 1'b1;
            write_exmem  = 1'b1;
            write_memwb  = 1'b1;
            write_pc     = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_RUN;
            drop_fetch_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            drop_fetch_q <= drop_fetch_d;
        end
    end

    assign dbg_state      = state_q;
    assign dbg_drop_fetch = drop_fetch_q;

    control_stall_unit_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .clr   (reset),
        .inc   (!write_pc),
        .count (stall_cnt)
    );

    control_stall_unit_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .clr   (reset),
        .inc   (branch_act || jump_act),
        .count (flush_cnt)
    );

    // Counts stall cycles of either miss, including the entering cycle
    // but not the release cycle.
    control_stall_unit_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clock (clock),
        .clr   (reset),
        .inc   (state_d != ST_RUN),
        .count (miss_cnt)
    );

endmodule

// File: tb/tb_control_stall_unit.sv
// tb_control_stall_unit
//   Two instances share all inputs:
//     dut_a: LOAD_LAT=1, BR_STAGE=3 (MEM), CNT_W=32
//     dut_b: LOAD_LAT=2, BR_STAGE=2 (EX),  CNT_W=4
//   Control vector bit order (9 bits, MSB first):
//     bubble_ifid bubble_idex bubble_exmem bubble_memwb
//     write_ifid write_idex write_exmem write_memwb write_pc
module tb_control_stall_unit;

    localparam logic [8:0] V_NORM = 9'b0000_1111_1;
    localparam logic [8:0] V_RST  = 9'b1111_1111_1;
    localparam logic [8:0] V_LU   = 9'b0100_0111_0;
    localparam logic [8:0] V_DM   = 9'b0001_0001_0;
    localparam logic [8:0] V_BR3  = 9'b1110_1111_1;
    localparam logic [8:0] V_BR2  = 9'b1100_1111_1;
    localparam logic [8:0] V_IM   = 9'b1000_1111_0;
    localparam logic [8:0] V_JMP  = 9'b1000_1111_1;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DMISS = 2'd1;
    localparam logic [1:0] S_IMISS = 2'd2;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [4:0] ifid_rs, ifid_rt, idex_rd, exmem_rd;
    logic       idex_memread, exmem_memread, exmem_memaccess;
    logic       Jump, PCSrc, icache_ready, dcache_ready;

    logic        b_ifid_a, b_idex_a, b_exmem_a, b_memwb_a;
    logic        w_ifid_a, w_idex_a, w_exmem_a, w_memwb_a, w_pc_a;
    logic [31:0] stall_cnt_a, flush_cnt_a, miss_cnt_a;
    logic [1:0]  state_a;
    logic        drop_a;

    logic        b_ifid_b, b_idex_b, b_exmem_b, b_memwb_b;
    logic        w_ifid_b, w_idex_b, w_exmem_b, w_memwb_b, w_pc_b;
    logic [3:0]  stall_cnt_b, flush_cnt_b, miss_cnt_b;
    logic [1:0]  state_b;
    logic        drop_b;

    control_stall_unit #(.REG_W(5), .LOAD_LAT(1), .BR_STAGE(3), .CNT_W(32)) dut_a (
        .clock (clock), .reset (reset),
        .ifid_rs (ifid_rs), .ifid_rt (ifid_rt),
        .idex_rd (idex_rd), .idex_memread (idex_memread),
        .exmem_rd (exmem_rd), .exmem_memread (exmem_memread),
        .exmem_memaccess (exmem_memaccess),
        .Jump (Jump), .PCSrc (PCSrc),
        .icache_ready (icache_ready), .dcache_ready (dcache_ready),
        .bubble_ifid (b_ifid_a), .bubble_idex (b_idex_a),
        .bubble_exmem (b_exmem_a), .bubble_memwb (b_memwb_a),
        .write_ifid (w_ifid_a), .write_idex (w_idex_a),
        .write_exmem (w_exmem_a), .write_memwb (w_memwb_a), .write_pc (w_pc_a),
        .stall_cnt (stall_cnt_a), .flush_cnt (flush_cnt_a), .miss_cnt (miss_cnt_a),
        .dbg_state (state_a), .dbg_drop_fetch (drop_a)
    );

    control_stall_unit #(.REG_W(5), .LOAD_LAT(2), .BR_STAGE(2), .CNT_W(4)) dut_b (
        .clock (clock), .reset (reset),
        .ifid_rs (ifid_rs), .ifid_rt (ifid_rt),
        .idex_rd (idex_rd), .idex_memread (idex_memread),
        .exmem_rd (exmem_rd), .exmem_memread (exmem_memread),
        .exmem_memaccess (exmem_memaccess),
        .Jump (Jump), .PCSrc (PCSrc),
        .icache_ready (icache_ready), .dcache_ready (dcache_ready),
        .bubble_ifid (b_ifid_b), .bubble_idex (b_idex_b),
        .bubble_exmem (b_exmem_b), .bubble_memwb (b_memwb_b),
        .write_ifid (w_ifid_b), .write_idex (w_idex_b),
        .write_exmem (w_exmem_b), .write_memwb (w_memwb_b), .write_pc (w_pc_b),
        .stall_cnt (stall_cnt_b), .flush_cnt (flush_cnt_b), .miss_cnt (miss_cnt_b),
        .dbg_state (state_b), .dbg_drop_fetch (drop_b)
    );

    logic [8:0] vec_a, vec_b;
    assign vec_a = {b_ifid_a, b_idex_a, b_exmem_a, b_memwb_a,
                    w_ifid_a, w_idex_a, w_exmem_a, w_memwb_a, w_pc_a};
    assign vec_b = {b_ifid_b, b_idex_b, b_exmem_b, b_memwb_b,
                    w_ifid_b, w_idex_b, w_exmem_b, w_memwb_b, w_pc_b};

    // ---------------- scoreboard ----------------
    logic [17:0] exp_q[$];
    logic [17:0] obs_q[$];
    int checks = 0;
    int errors = 0;

    // ---------------- driver tasks ----------------
    task automatic idle();
        ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rd = 5'd0; exmem_rd = 5'd0;
        idex_memread = 1'b0; exmem_memread = 1'b0; exmem_memaccess = 1'b0;
        Jump = 1'b0; PCSrc = 1'b0; icache_ready = 1'b1; dcache_ready = 1'b1;
    endtask

    // Inputs are set at posedge+1; outputs are sampled at the negedge and
    // the task returns at the following posedge+1.
    task automatic step(input logic [8:0] ea, input logic [8:0] eb);
        exp_q.push_back({ea, eb});
        @(negedge clock);
        obs_q.push_back({vec_a, vec_b});
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [17:0] e, o;
        reset = 1'b1;
        idle();
        Jump = 1'b1; PCSrc = 1'b1; icache_ready = 1'b0;
        step(V_RST, V_RST);
        reset = 1'b0;
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 18'hx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL reset_vec: got %b expected %b", o, e); end
        end
        checks++;
        if (state_a !== S_RUN || drop_a !== 1'b0 || state_b !== S_RUN) begin
            errors++; $display("FAIL reset_state: got %0d/%0d/%0d expected 0/0/0", state_a, drop_a, state_b);
        end
        checks++;
        if (stall_cnt_a !== 32'd0 || flush_cnt_a !== 32'd0 || miss_cnt_a !== 32'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d/%0d/%0d expected 0/0/0", stall_cnt_a, flush_cnt_a, miss_cnt_a);
        end
    endtask

    task automatic test_load_use();
        logic [17:0] e, o;
        do_reset();
        idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd2;
        step(V_LU, V_LU);
        idle();
        step(V_NORM, V_NORM);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 18'hx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL load_use_vec: got %b expected %b", o, e); end
        end
        checks++;
        if (stall_cnt_a !== 32'd1) begin errors++; $display("FAIL load_use_stall_cnt: got %0d expected 1", stall_cnt_a); end
    endtask

    task automatic test_rd_zero();
        logic [17:0] e, o;
        do_reset();
        idex_memread = 1'b1; idex_rd = 5'd0; ifid_rt = 5'd0; ifid_rs = 5'd3;
        exmem_memread = 1'b1; exmem_rd = 5'd0;
        step(V_NORM, V_NORM);
        // A random nonzero source that differs from rd never stalls either
        idex_rd = 5'($urandom_range(1, 15));
        ifid_rs = idex_rd + 5'd1; ifid_rt = idex_rd + 5'd2; exmem_memread = 1'b0;
        step(V_NORM, V_NORM);
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 18'hx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL rd_zero_vec: got %b expected %b", o, e); end
        end
        checks++;
        if (stall_cnt_a !== 32'd0) begin errors++; $display("FAIL rd_zero_stall_cnt: got %0d expected 0", stall_cnt_a); end
    endtask

    task automatic test_dmiss();
        logic [17:0] e, o;
        logic [1:0]  st_mid;
        do_reset();
        exmem_memaccess = 1'b1; dcache_ready = 1'b0;
        step(V_DM, V_DM);
        st_mid = state_a;
        icache_ready = 1'b0;           // simultaneous I-miss: D-miss wins
        step(V_DM, V_DM);
        icache_ready = 1'b1; PCSrc = 1'b1;  // branch ignored during D-miss
        step(V_DM, V_DM);
        PCSrc = 1'b0;
        step(V_DM, V_DM);
        dcache_ready = 1'b1;
        step(V_NORM, V_NORM);
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 18'hx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL dmiss_vec: got %b expected %b", o, e); end
        end
        checks++;
        if (st_mid !== S_DMISS) begin errors++; $display("FAIL dmiss_state: got %0d expected %0d", st_mid, S_DMISS); end
        checks++;
        if (state_a !== S_RUN) begin errors++; $display("FAIL dmiss_release_state: got %0d expected %0d", state_a, S_RUN); end
        checks++;
        if (miss_cnt_a !== 32'd4 || stall_cnt_a !== 32'd4 || flush_cnt_a !== 32'd0) begin
            errors++; $display("FAIL dmiss_cnt: got miss %0d stall %0d flush %0d expected 4 4 0", miss_cnt_a, stall_cnt_a, flush_cnt_a);
        end
    endtask

    task automatic test_imiss_branch();
        logic [17:0] e, o;
        logic        drop_mid;
        do_reset();
        icache_ready = 1'b0;
        step(V_IM, V_IM);
        PCSrc = 1'b1;
        step(V_BR3, V_BR2);
        drop_mid = drop_a;
        PCSrc = 1'b0;
        step(V_IM, V_IM);
        icache_ready = 1'b1;
        step(V_JMP, V_JMP);            // stale fetch discarded
        step(V_NORM, V_NORM);          // discard happens only once
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 18'hx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL imiss_branch_vec: got %b expected %b", o, e); end
        end
        checks++;
        if (drop_mid !== 1'b1) begin errors++; $display("FAIL imiss_drop_set: got %b expected 1", drop_mid); end
        checks++;
        if (drop_a !== 1'b0 || state_a !== S_RUN) begin
            errors++; $display("FAIL imiss_release: got drop %b state %0d expected 0 0", drop_a, state_a);
        end
        checks++;
        if (flush_cnt_a !== 32'd1 || miss_cnt_a !== 32'd3 || stall_cnt_a !== 32'd2) begin
            errors++; $display("FAIL imiss_cnt: got flush %0d miss %0d stall %0d expected 1 3 2", flush_cnt_a, miss_cnt_a, stall_cnt_a);
        end
    endtask

    task automatic test_load_lat();
        logic [17:0] e, o;
        do_reset();
        exmem_memread = 1'b1; exmem_rd = 5'd7; ifid_rs = 5'd7; ifid_rt = 5'd1;
        step(V_NORM, V_LU);            // only LOAD_LAT=2 sees the MEM load
        idle();
        idex_memread = 1'b1; idex_rd = 5'd9; ifid_rt = 5'd9; ifid_rs = 5'd4;
        step(V_LU, V_LU);
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 18'hx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL load_lat_vec: got %b expected %b", o, e); end
        end
        checks++;
        if (stall_cnt_a !== 32'd1 || stall_cnt_b !== 4'd2) begin
            errors++; $display("FAIL load_lat_cnt: got a %0d b %0d expected 1 2", stall_cnt_a, stall_cnt_b);
        end
    endtask

    task automatic test_priority();
        logic [17:0] e, o;
        do_reset();
        Jump = 1'b1;
        step(V_JMP, V_JMP);
        idex_memread = 1'b1; idex_rd = 5'd3; ifid_rs = 5'd3;
        step(V_LU, V_LU);              // load-use beats jump
        Jump = 1'b0; PCSrc = 1'b1;
        step(V_BR3, V_BR2);            // branch beats load-use
        idle();
        Jump = 1'b1; icache_ready = 1'b0;
        step(V_IM, V_IM);              // I-miss beats jump
        idle();
        step(V_NORM, V_NORM);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 18'hx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL priority_vec: got %b expected %b", o, e); end
        end
        checks++;
        if (flush_cnt_a !== 32'd2 || stall_cnt_a !== 32'd2 || miss_cnt_a !== 32'd1) begin
            errors++; $display("FAIL priority_cnt: got flush %0d stall %0d miss %0d expected 2 2 1", flush_cnt_a, stall_cnt_a, miss_cnt_a);
        end
    endtask

    task automatic test_saturation_reset();
        logic [17:0] e, o;
        logic [1:0]  st_mid;
        logic        drop_mid;
        do_reset();
        idex_memread = 1'b1; idex_rd = 5'd12; ifid_rt = 5'd12;
        for (int i = 0; i < 20; i++) begin
            step(V_LU, V_LU);
        end
        idle();
        checks++;
        if (stall_cnt_b !== 4'd15) begin errors++; $display("FAIL sat_cnt_b: got %0d expected 15", stall_cnt_b); end
        checks++;
        if (stall_cnt_a !== 32'd20) begin errors++; $display("FAIL sat_cnt_a: got %0d expected 20", stall_cnt_a); end
        // Build up IMISS with a pending discard, then preempt with a D-miss
        icache_ready = 1'b0;
        step(V_IM, V_IM);
        PCSrc = 1'b1;
        step(V_BR3, V_BR2);
        PCSrc = 1'b0; exmem_memaccess = 1'b1; dcache_ready = 1'b0;
        step(V_DM, V_DM);
        st_mid = state_a;
        drop_mid = drop_a;
        reset = 1'b1;
        step(V_RST, V_RST);
        reset = 1'b0;
        idle();
        checks++;
        if (st_mid !== S_DMISS || drop_mid !== 1'b1) begin
            errors++; $display("FAIL pre_reset_state: got %0d drop %b expected %0d drop 1", st_mid, drop_mid, S_DMISS);
        end
        checks++;
        if (state_a !== S_RUN || drop_a !== 1'b0 || state_b !== S_RUN || drop_b !== 1'b0) begin
            errors++; $display("FAIL mid_miss_reset_state: got %0d/%b expected 0/0", state_a, drop_a);
        end
        checks++;
        if (stall_cnt_b !== 4'd0 || stall_cnt_a !== 32'd0 || flush_cnt_a !== 32'd0 || miss_cnt_a !== 32'd0) begin
            errors++; $display("FAIL mid_miss_reset_cnt: got %0d %0d %0d %0d expected all 0", stall_cnt_b, stall_cnt_a, flush_cnt_a, miss_cnt_a);
        end
        step(V_NORM, V_NORM);          // no stale discard after reset
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 18'hx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL sat_reset_vec: got %b expected %b", o, e); end
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        reset = 1'b1;
        idle();
        @(posedge clock);
        #1;
        test_reset();
        test_load_use();
        test_rd_zero();
        test_dmiss();
        test_imiss_branch();
        test_load_lat();
        test_priority();
        test_saturation_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
